mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_divider.sv | 32 +++
 rtl/mult_div_unit.sv | 140 ++++++++++++++
 tb/tb_mult_div_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, FSM states, default latencies.
// The DIV state exists only when the DIV_EN macro is defined.
package mdu_pkg;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL
`ifdef DIV_EN
    , ST_DIV
`endif
  } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit divider: signed (truncate toward zero, remainder takes the
// dividend's sign) or unsigned quotient/remainder, plus a divide-by-zero flag.
module mdu_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  always_comb begin
    a_neg    = is_signed & dividend[31];
    b_neg    = is_signed & divisor[31];
    a_mag    = a_neg ? (32'd0 - dividend) : dividend;
    b_mag    = b_neg ? (32'd0 - divisor)  : divisor;
    div_zero = (divisor == '0);
    q_mag    = '0;
    r_mag    = '0;
    if (!div_zero) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    // 0x80000000 / -1 falls out as magnitude 0x80000000, whose negation wraps to itself.
    quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    remainder = a_neg ? (32'd0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and MTHI/MTLO moves.
// Define DIV_EN to include DIV/DIVU and the mdu_divider datapath.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] input_1,
  input  logic [31:0] input_2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic [63:0]      mul_a, mul_b, prod;

  // Sign-extending both operands to 64 bits lets one multiplier serve MULT and MULTU.
  always_comb begin
    mul_a = {{32{sgn_q & a_q[31]}}, a_q};
    mul_b = {{32{sgn_q & b_q[31]}}, b_q};
    prod  = mul_a * mul_b;
  end

`ifdef DIV_EN
  logic [31:0] quo, rem;
  logic        div_zero;

  mdu_divider u_div (
    .dividend  (a_q),
    .divisor   (b_q),
    .is_signed (sgn_q),
    .quotient  (quo),
    .remainder (rem),
    .div_zero  (div_zero)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              state_d = ST_MUL;
              cnt_d   = CNT_W'(MUL_CYCLES);
              a_d     = input_1;
              b_d     = input_2;
              sgn_d   = ~md_op[0];
            end
`ifdef DIV_EN
            OP_DIV, OP_DIVU: begin
              state_d = ST_DIV;
              cnt_d   = CNT_W'(DIV_CYCLES);
              a_d     = input_1;
              b_d     = input_2;
              sgn_d   = ~md_op[0];
            end
`endif
            OP_MTHI: hi_d = input_1;
            OP_MTLO: lo_d = input_1;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = prod;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef DIV_EN
      ST_DIV: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!div_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized ops
// compared against an arithmetic HI/LO reference model. Honors DIV_EN.
module tb_mult_div_unit;

  localparam int unsigned MUL_C = 5;
  localparam int unsigned DIV_C = 10;
`ifdef DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] input_1, input_2;
  logic        busy;
  logic [31:0] hi, lo;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(
    .MUL_CYCLES (MUL_C),
    .DIV_CYCLES (DIV_C)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .md_op   (md_op),
    .input_1 (input_1),
    .input_2 (input_2),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: latency and resulting HI/LO from the architectural rules.
  task automatic predict(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int unsigned lat, output logic [31:0] nh, output logic [31:0] nl);
    longint      sa, sb, p, q, r;
    logic [63:0] pu;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    nh  = exp_hi;
    nl  = exp_lo;
    lat = 0;
    case (op)
      3'd0: begin p = sa * sb; {nh, nl} = p; lat = MUL_C; end
      3'd1: begin pu = 64'(a) * 64'(b); {nh, nl} = pu; lat = MUL_C; end
      3'd2: if (DIV_ON) begin
        lat = DIV_C;
        if (b != 0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      end
      3'd3: if (DIV_ON) begin
        lat = DIV_C;
        if (b != 0) begin nl = a / b; nh = a % b; end
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: ;
    endcase
  endtask

  // Entered and left on a negedge; the next op may start in the first idle cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned lat, n;
    logic [31:0] nh, nl;
    predict(op, a, b, lat, nh, nl);
    start = 1'b1; md_op = op; input_1 = a; input_2 = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'($urandom_range(0, 7)); input_1 = $urandom; input_2 = $urandom;
    if (lat > 0) begin
      check({tag, " hold_hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " hold_lo"}, 64'(lo), 64'(exp_lo));
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
    check({tag, " busy_cycles"}, 64'(n), 64'(lat));
    exp_hi = nh;
    exp_lo = nl;
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int unsigned lat, n;
    logic [31:0] nh, nl, a, b;
    logic [2:0]  op, abort_op;

    rst_n = 1'b0; start = 1'b0; md_op = '0; input_1 = '0; input_2 = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult hi const", 64'(hi), 64'hFFFF_FFFF);
    check("mult lo const", 64'(lo), 64'hFFFF_FFFA);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu hi const", 64'(hi), 64'hFFFF_FFFE);
    check("multu lo const", 64'(lo), 64'h0000_0001);

    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mthi", 3'd4, 32'h1234_5678, 32'h0);
    run_op("divu_zero", 3'd3, 32'h0000_0005, 32'h0);
    check("divu_zero hi const", 64'(hi), 64'h1234_5678);
    run_op("mtlo", 3'd5, 32'h0BAD_F00D, 32'h0);
    run_op("rsv6", 3'd6, 32'hDEAD_BEEF, 32'h1);
    run_op("rsv7", 3'd7, 32'hCAFE_F00D, 32'h2);

    // MTLO pulsed at busy cycle 2 of a MULT must be ignored.
    predict(3'd0, 32'h0001_2345, 32'h0000_0777, lat, nh, nl);
    start = 1'b1; md_op = 3'd0; input_1 = 32'h0001_2345; input_2 = 32'h0000_0777;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 2) begin start = 1'b1; md_op = 3'd5; input_1 = 32'h0000_AAAA; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("mtlo_busy busy_cycles", 64'(n), 64'(lat));
    exp_hi = nh; exp_lo = nl;
    check("mtlo_busy hi", 64'(hi), 64'(exp_hi));
    check("mtlo_busy lo", 64'(lo), 64'(exp_lo));

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ((op == 3'd2 || op == 3'd3) && $urandom_range(0, 4) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b);
    end

    // Reset at busy cycle 4 aborts the operation with no later writeback.
    abort_op = DIV_ON ? 3'd2 : 3'd0;
    start = 1'b1; md_op = abort_op; input_1 = 32'h7654_3210; input_2 = 32'h0000_0013;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 4 && busy === 1'b1) begin n++; @(negedge clk); end
    check("abort reached cycle4", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'(0));
    check("abort hi", 64'(hi), 64'(0));
    check("abort lo", 64'(lo), 64'(0));
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_abort busy", 64'(busy), 64'(0));
    check("post_abort hi", 64'(hi), 64'(exp_hi));
    check("post_abort lo", 64'(lo), 64'(exp_lo));

    run_op("after_abort mult", 3'd0, 32'h8000_0000, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
